ecc_sed_enc_arbiter: RTL and testbench

//  Shares one ecc_sed_encoder between NUM_REQ requesters via round-robin arbitration.
//  The granted request's 12-bit data is encoded and pushed, with its source ID, into a 2-entry output buffer.
//  The buffer drains over a valid/ready link to the downstream storage/link writer.

---
 rtl/ecc_sed_enc_arbiter_pkg.sv | 12 +
 rtl/ecc_sed_enc_arbiter_if.sv | 26 ++
 rtl/ecc_sed_enc_arbiter_encoder.sv | 9 +
 rtl/ecc_sed_enc_arbiter.sv | 68 ++++++
 tb/tb_ecc_sed_enc_arbiter.sv | 126 ++++++++++++
 5 files changed

// File: rtl/ecc_sed_enc_arbiter_pkg.sv
// ecc_sed_pkg: shared widths, codeword/buffer-entry types and buffer occupancy states
package ecc_sed_pkg;
  localparam int DATA_W = 12;
  localparam int CW_W = 13;
  localparam int SRC_MAX_W = 3;
  typedef logic [CW_W-1:0] cw_t;
  typedef struct packed {
    cw_t cw;
    logic [SRC_MAX_W-1:0] src;
  } buf_entry_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;
endpackage

// File: rtl/ecc_sed_enc_arbiter_if.sv
// ecc_sed_enc_arbiter_if: request side and output-buffer side signals of the shared encoder
interface ecc_sed_enc_arbiter_if
  import ecc_sed_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
);
  logic enable;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic out_valid;
  logic out_ready;
  cw_t out_codeword;
  logic [SRC_W-1:0] out_src;
  logic [CNT_W-1:0] xfer_cnt;
  modport master (
    output enable, req_valid, req_data, out_ready,
    input req_ready, out_valid, out_codeword, out_src, xfer_cnt
  );
  modport slave (
    input enable, req_valid, req_data, out_ready,
    output req_ready, out_valid, out_codeword, out_src, xfer_cnt
  );
endinterface

// File: rtl/ecc_sed_enc_arbiter_encoder.sv
// ecc_sed_encoder: single-error-detect encoder, even parity bit prepended to the data
module ecc_sed_encoder
  import ecc_sed_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output cw_t               o_cw
);
  assign o_cw = {^i_data, i_data};
endmodule

// File: rtl/ecc_sed_enc_arbiter.sv
// ecc_sed_enc_arbiter: round-robin arbiter sharing one SED encoder, feeding a 2-entry output buffer
module ecc_sed_enc_arbiter
  import ecc_sed_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
)(
  input logic clk,
  input logic rst,
  ecc_sed_enc_arbiter_if.slave bus
);
  buf_state_t r_state, w_state_nxt;
  buf_entry_t r_buf [2];
  logic r_wr, r_rd;
  logic [SRC_W-1:0] r_last, w_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] w_data;
  logic w_found, w_push, w_pop;
  cw_t w_cw;
  // Descending scan so the nearest requester after last_grant is the final (winning) assignment.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_data = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[SRC_W'((int'(r_last) + k) % NUM_REQ)]) begin
        w_grant = SRC_W'((int'(r_last) + k) % NUM_REQ);
        w_found = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant == SRC_W'(i)) w_data = bus.req_data[DATA_W*i +: DATA_W];
  end
  ecc_sed_encoder u_enc (.i_data(w_data), .o_cw(w_cw));
  // rst gates the grant so req_ready stays low for the whole reset pulse.
  assign w_push = w_found & bus.enable & (r_state != FULL) & ~rst;
  assign w_pop = (r_state != EMPTY) & bus.out_ready;
  assign bus.req_ready = w_push ? (NUM_REQ'(1) << w_grant) : '0;
  assign bus.out_valid = r_state != EMPTY;
  assign bus.out_codeword = r_buf[r_rd].cw;
  assign bus.out_src = SRC_W'(r_buf[r_rd].src);
  assign bus.xfer_cnt = r_cnt;
  always_comb begin
    w_state_nxt = (w_push == w_pop) ? r_state :
                  w_push ? ((r_state == EMPTY) ? ONE : FULL) :
                  ((r_state == FULL) ? ONE : EMPTY);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      r_last <= SRC_W'(NUM_REQ - 1);
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_buf[r_wr] <= '{cw: w_cw, src: SRC_MAX_W'(w_grant)};
        r_wr <= ~r_wr;
        r_last <= w_grant;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_pop) r_rd <= ~r_rd;
    end
  end
endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// tb_ecc_sed_enc_arbiter: table-driven vectors with a scoreboard for the buffered codewords
module tb_ecc_sed_enc_arbiter;
  import ecc_sed_pkg::*;
  typedef struct {
    logic rst;
    logic en;
    logic [3:0] v;
    logic ordy;
    logic [3:0] exp;
  } vec_t;
  typedef struct {
    cw_t cw;
    logic [1:0] src;
  } sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_err = 0;
  int n_chk = 0;
  int m_cnt = 0;
  int m_xfer = 0;
  logic [11:0] d [4];
  sb_t sb [$];
  vec_t tbl [$];
  always #5 clk = ~clk;
  ecc_sed_enc_arbiter_if #(.NUM_REQ(4), .SRC_W(2), .CNT_W(16)) u_if ();
  ecc_sed_enc_arbiter_if #(.NUM_REQ(4), .SRC_W(2), .CNT_W(4)) u_if4 ();
  ecc_sed_enc_arbiter #(.NUM_REQ(4), .SRC_W(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  ecc_sed_enc_arbiter #(.NUM_REQ(4), .SRC_W(2), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave));
  function automatic cw_t enc(input logic [11:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) n += int'(x[i]);
    return {n[0], x};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic en, input logic [3:0] v, input logic ordy, input logic [3:0] exp);
    tbl.push_back('{rst: r, en: en, v: v, ordy: ordy, exp: exp});
  endtask
  task automatic apply(input vec_t t);
    int g;
    int pop;
    rst = t.rst;
    u_if.enable = t.en;
    u_if.req_valid = t.v;
    u_if.out_ready = t.ordy;
    u_if.req_data = {d[3], d[2], d[1], d[0]};
    if (t.rst) begin
      sb.delete();
      m_cnt = 0;
      m_xfer = 0;
    end
    @(negedge clk);
    check("ready", 32'(u_if.req_ready), 32'(t.exp));
    check("out_valid", 32'(u_if.out_valid), 32'(m_cnt != 0));
    check("xfer_cnt", 32'(u_if.xfer_cnt), 32'(m_xfer));
    if (t.rst) check("reset_head", 32'({u_if.out_codeword, u_if.out_src}), 32'(0));
    pop = 0;
    if (m_cnt != 0 && sb.size() != 0) begin
      check("head_cw", 32'(u_if.out_codeword), 32'(sb[0].cw));
      check("head_src", 32'(u_if.out_src), 32'(sb[0].src));
      if (t.ordy) begin
        void'(sb.pop_front());
        pop = 1;
      end
    end
    if (t.exp != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (t.exp[i]) g = i;
      sb.push_back('{cw: enc(d[g]), src: 2'(g)});
      d[g] = d[g] + 12'h2A5;
      m_xfer++;
      m_cnt++;
    end
    m_cnt -= pop;
    @(posedge clk);
    #1;
  endtask
  initial begin
    d[0] = 12'hABC; d[1] = 12'h123; d[2] = 12'h0F0; d[3] = 12'h7FF;
    u_if.enable = 1'b0; u_if.req_valid = '0; u_if.req_data = '0; u_if.out_ready = 1'b0;
    u_if4.enable = 1'b0; u_if4.req_valid = '0; u_if4.req_data = '0; u_if4.out_ready = 1'b0;
    // reset, then single request from 0 and its one-cycle latency
    add(1, 1, 4'b1111, 1, 4'b0000); add(1, 1, 4'b1111, 1, 4'b0000);
    add(0, 1, 4'b0001, 1, 4'b0001); add(0, 1, 4'b0000, 1, 4'b0000);
    // all four valid, continuous drain
    add(0, 1, 4'b1111, 1, 4'b0010); add(0, 1, 4'b1111, 1, 4'b0100); add(0, 1, 4'b1111, 1, 4'b1000);
    add(0, 1, 4'b1111, 1, 4'b0001); add(0, 1, 4'b1111, 1, 4'b0010); add(0, 1, 4'b1111, 1, 4'b0100);
    add(0, 1, 4'b0000, 1, 4'b0000);
    // requesters 1 and 3 alternate, wrapping past 0
    add(0, 1, 4'b1010, 1, 4'b1000); add(0, 1, 4'b1010, 1, 4'b0010);
    add(0, 1, 4'b1010, 1, 4'b1000); add(0, 1, 4'b1010, 1, 4'b0010);
    add(0, 1, 4'b0000, 1, 4'b0000);
    // enable low with one entry buffered, then resume at last_grant+1
    add(0, 1, 4'b0100, 0, 4'b0100); add(0, 0, 4'b1111, 0, 4'b0000);
    add(0, 0, 4'b1111, 1, 4'b0000); add(0, 0, 4'b1111, 1, 4'b0000);
    add(0, 1, 4'b1111, 0, 4'b1000); add(0, 1, 4'b1111, 0, 4'b0001); add(0, 1, 4'b1111, 0, 4'b0000);
    // FULL pop frees space only for the next cycle
    add(0, 1, 4'b1111, 1, 4'b0000); add(0, 1, 4'b1111, 0, 4'b0010); add(0, 1, 4'b1111, 0, 4'b0000);
    // reset with FULL buffer, then requester 0 has priority again
    add(1, 1, 4'b1111, 0, 4'b0000); add(1, 1, 4'b1111, 0, 4'b0000);
    add(0, 1, 4'b1111, 0, 4'b0001); add(0, 1, 4'b1111, 0, 4'b0010); add(0, 1, 4'b1111, 0, 4'b0000);
    add(0, 1, 4'b1111, 1, 4'b0000); add(0, 1, 4'b1111, 1, 4'b0100);
    add(0, 1, 4'b0000, 1, 4'b0000); add(0, 1, 4'b0000, 1, 4'b0000);
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);
    check("first_cw_const", 32'(enc(12'hABC)), 32'(13'h1ABC));
    // narrow counter wraps: 17 accepted transfers leave 1
    u_if4.enable = 1'b1; u_if4.req_valid = 4'b0001; u_if4.req_data = 48'h000_000_000_555; u_if4.out_ready = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    u_if4.req_valid = '0;
    @(negedge clk);
    check("xfer_cnt_wrap", 32'(u_if4.xfer_cnt), 32'(1));
    check("wrap_head_src", 32'(u_if4.out_src), 32'(0));
    check("wrap_head_cw", 32'(u_if4.out_codeword), 32'(enc(12'h555)));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
